// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered UART transmitter. Characters written on the iobus-side write port
//   are queued in a FIFO and serialised LSB-first on txd as
//   start / DATA_BITS data / optional parity / STOP_BITS stop. When another
//   character is waiting at the end of a stop period, its start bit follows
//   immediately with no idle gap.
//
//   Handshake: a write is accepted on a rising clk edge where wr_en=1 and the
//   registered full=0. A write while full=1 is dropped and the FIFO contents
//   are unchanged. No back-pressure exists beyond full.
//
// Parameters
//   CLK_FREQ   clock frequency in Hz
//   BAUD       line rate; bit period DIV = CLK_FREQ / BAUD (must be >= 2)
//   DATA_BITS  character width, 5..9
//   PARITY     0 none, 1 odd, 2 even
//   STOP_BITS  1 or 2
//   FIFO_DEPTH entries, power of two, >= 2
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   wr_en      write strobe
//   wr_data    character to send
//   full       FIFO holds FIFO_DEPTH entries (registered)
//   count      entries currently held in the FIFO
//   busy       frame on the line or FIFO non-empty (registered)
//   txd        serial output, idle high (registered)
//   fsm_state  transmitter state encoding, for observation:
//              0 idle, 1 start, 2 data, 3 parity, 4 stop
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              wr_en,
   input  logic [DATA_BITS-1:0]              wr_data,
   output logic                              full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
   output logic                              busy,
   output logic                              txd,
   output logic [2:0]                        fsm_state
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int BCW = (DIV > 2) ? $clog2(DIV) : 1;

   localparam logic [BCW-1:0] BAUD_LAST = BCW'(DIV - 1);
   localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic [CW-1:0]  DEPTH_CNT = CW'(FIFO_DEPTH);
   localparam logic           ODD_PAR   = (PARITY == 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // ---------------------------------------------------------------------------
   // FIFO storage and pointers
   // ---------------------------------------------------------------------------
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        count_d;
   logic                 full_d;
   logic                 push;
   logic                 pop;
   logic [DATA_BITS-1:0] rd_data;

   // full is the registered flag, so a pop on the same edge never rescues
   // a write to a full FIFO.
   assign push    = wr_en && !full;
   assign rd_data = mem[rd_ptr];

   always_comb begin
      count_d = count;
      if (push && !pop) begin
         count_d = count + 1'b1;
      end else if (!push && pop) begin
         count_d = count - 1'b1;
      end
   end

   assign full_d = (count_d == DEPTH_CNT);

   // Storage has no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_d;
         full  <= full_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Transmit FSM
   // ---------------------------------------------------------------------------
   state_t               state;
   state_t               state_d;
   logic [BCW-1:0]       baud_cnt;
   logic [BCW-1:0]       baud_d;
   logic [3:0]           bit_cnt;
   logic [3:0]           bit_d;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] shift_d;
   logic                 par_bit;
   logic                 par_d;
   logic                 txd_d;
   logic                 busy_d;
   logic                 bit_done;

   assign bit_done  = (baud_cnt == BAUD_LAST);
   assign fsm_state = state;

   always_comb begin
      state_d = state;
      baud_d  = bit_done ? '0 : baud_cnt + 1'b1;
      bit_d   = bit_cnt;
      shift_d = shift;
      par_d   = par_bit;
      pop     = 1'b0;
      txd_d   = 1'b1;
      busy_d  = 1'b0;

      case (state)
         S_IDLE: begin
            baud_d = '0;
            if (count != '0) begin
               pop     = 1'b1;
               shift_d = rd_data;
               par_d   = (^rd_data) ^ ODD_PAR;
               bit_d   = '0;
               state_d = S_START;
            end
         end

         S_START: begin
            if (bit_done) begin
               bit_d   = '0;
               state_d = S_DATA;
            end
         end

         S_DATA: begin
            if (bit_done) begin
               shift_d = shift >> 1;
               if (bit_cnt == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_cnt + 1'b1;
               end
            end
         end

         S_PARITY: begin
            if (bit_done) begin
               bit_d   = '0;
               state_d = S_STOP;
            end
         end

         S_STOP: begin
            // bit_cnt counts stop bits; the last cycle of the last stop bit
            // either chains straight into the next start bit or idles.
            if (bit_done) begin
               if (bit_cnt == STOP_LAST) begin
                  bit_d = '0;
                  if (count != '0) begin
                     pop     = 1'b1;
                     shift_d = rd_data;
                     par_d   = (^rd_data) ^ ODD_PAR;
                     state_d = S_START;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_d = bit_cnt + 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
         end
      endcase

      // txd is registered: it is derived from the state being entered so the
      // line changes on the same edge as the state.
      case (state_d)
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = shift_d[0];
         S_PARITY: txd_d = par_d;
         default:  txd_d = 1'b1;
      endcase

      busy_d = (state_d != S_IDLE) || (count_d != '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         par_bit  <= 1'b0;
         txd      <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         baud_cnt <= baud_d;
         bit_cnt  <= bit_d;
         shift    <= shift_d;
         par_bit  <= par_d;
         txd      <= txd_d;
         busy     <= busy_d;
      end
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter: the successor to the fixed 8N1 serial sender that drives `txd` on the Arty S7 board. It accepts words from the iobus-side write port into an internal FIFO and serialises them LSB-first. Character width, parity mode, stop-bit count, baud rate and FIFO depth are all configurable. It sits between the memory-mapped iobus and the board `txd` pin. Back-to-back FIFO entries are sent with no idle gap.

## Interface
- `CLK_FREQ`, 50_000_000, input clock frequency in Hz.
- `BAUD`, 115200, line rate; bit period `DIV = CLK_FREQ / BAUD` (integer truncation), must be ≥ 2.
- `DATA_BITS`, 8, character width, 5..9.
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1, stop-bit count, 1 or 2.
- `FIFO_DEPTH`, 16, FIFO entries, power of two, ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe; pushes `wr_data` when `full` is low.
- `wr_data`  in  DATA_BITS  character to send.
- `full`  out  1  FIFO holds FIFO_DEPTH entries (registered).
- `count`  out  $clog2(FIFO_DEPTH+1)  number of entries currently in the FIFO.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `txd`  out  1  serial output; idle high.

## Operation
- Reset (`reset` low, any time, asynchronous):
  - FIFO pointers cleared; `count`=0, `full`=0, `busy`=0, `txd`=1.
  - FSM goes to IDLE.
  - A frame in progress is abandoned immediately, with no completion; `txd` returns high.
- Write: at a rising edge with `wr_en`=1 and `full`=0, `wr_data` is stored and `count` increments.
  - When `wr_en`=1 and `full`=1 the write is dropped silently; FIFO contents are unchanged.
  - `full` is the registered value at the edge. A pop on the same edge does not make a write to a full FIFO succeed.
- Simultaneous push and pop: both take effect and `count` is unchanged.
- FSM states:
  - IDLE: `txd`=1. If `count`≠0, pop the head into the shift register, clear the bit counter, go to START.
  - START: `txd`=0 for DIV cycles, then DATA.
  - DATA: `txd`=shift[0] for DIV cycles per bit, shifting right. After DATA_BITS bits go to PARITY if PARITY≠0, else STOP.
  - PARITY: `txd` = XOR of all data bits (even), or its inverse (odd), for DIV cycles, then STOP.
  - STOP: `txd`=1 for STOP_BITS×DIV cycles.
    - At the last cycle, if `count`≠0, pop and go directly to START, so the next start bit follows with no gap.
    - Otherwise go to IDLE.
- Baud counter: counts 0..DIV-1 and is cleared on every state entry. A bit boundary occurs when the counter reaches DIV-1.
- `busy` = (state≠IDLE) | (`count`≠0), registered.
- Pointers wrap modulo FIFO_DEPTH; `count` width distinguishes full from empty.

## Timing
- Write to an empty FIFO in IDLE at edge N:
  - `count`=1 after N.
  - Pop at N+1; `txd` falls after edge N+1; `count` returns to 0 after N+1.
  - `busy` rises after N.
- Frame length = DIV × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- `full` and `count` update on the same edge as the push or pop that changes them.
- `busy` falls on the edge that returns the FSM to IDLE, when the FIFO is empty.

## Test plan
Unless stated, benches use CLK_FREQ=1_000_000, BAUD=100_000 (DIV=10).

- Reset check: hold `reset` low, then release. Required: `txd`=1, `busy`=0, `full`=0, `count`=0. Assert reset mid-frame: `txd`=1 within the same cycle and the FSM is in IDLE.
- 8N1, write 0xA5 once. Required: `txd` falls one edge after the write. Bits sampled at mid-bit read 0,1,0,1,0,0,1,0,1 followed by 1 (start, data LSB-first, stop). Total frame 100 cycles. `busy` low at cycle 101.
- PARITY=2, STOP_BITS=2, DATA_BITS=7, write 0x53 (four ones). Required: parity bit=0, two stop bits, frame 110 cycles. With PARITY=1 the parity bit=1.
- FIFO_DEPTH=4, write 6 words 0x01..0x06 on consecutive cycles. Required:
  - First pop on the cycle after the first write; writes 1–5 accepted, `full`=1 after the 5th write.
  - 6th word dropped.
  - Line carries 0x01..0x05 back-to-back (the start bit immediately follows the stop bit), then idle.
- Simultaneous push/pop: with `count`=2, write on the exact edge the FSM pops. Required: `count` stays 2 and no word is lost or duplicated on the line.
- Pointer wrap: stream 3×FIFO_DEPTH random words while keeping the FIFO partly full. Required: received sequence equals written sequence.
